// File: rtl/note_seq_if.sv
// note_seq_if: keyboard-side and tone-generator-side signals of the note sequencer.
//   load_n, playback : active-low key levels from the keyboard converter
//   clear            : active-high buffer clear level
//   note, octave     : note code (0 = rest, 1..12 = A..G#) and octave (0..3)
//   out_note, out_octave, note_on : tone generator drive
//   playing, count, full, empty, overflow : sequencer status
// The sequencer uses the slave modport; whoever drives the keys uses master.
interface note_seq_if #(
    parameter int ADDR_W = 5
);
    logic              load_n;
    logic              playback;
    logic              clear;
    logic [3:0]        note;
    logic [1:0]        octave;
    logic [3:0]        out_note;
    logic [1:0]        out_octave;
    logic              note_on;
    logic              playing;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output load_n, playback, clear, note, octave,
        input  out_note, out_octave, note_on, playing, count, full, empty, overflow
    );

    modport slave (
        input  load_n, playback, clear, note, octave,
        output out_note, out_octave, note_on, playing, count, full, empty, overflow
    );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: record/playback controller for the keyboard note path.
// Each load key press stores {octave, note} in a linear buffer; a playback
// key press replays the stored notes in order, each held NOTE_TICKS cycles.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : note_seq_if slave (key inputs, tone outputs, buffer status)
module note_sequencer #(
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5,
    parameter int NOTE_TICKS = 12500000,
    parameter int TICK_W     = 24
) (
    input  logic       clock,
    input  logic       reset,
    note_seq_if.slave  bus
);
    typedef struct packed {
        logic [1:0] octave;
        logic [3:0] note;
    } entry_t;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    logic [0:0]        state;
    entry_t            mem [DEPTH];
    logic              load_q;
    logic              play_q;
    logic              reset_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [TICK_W-1:0] hold;
    entry_t            out_entry;
    logic              note_on;
    logic              playing;
    logic              overflow;

    logic              load_req;
    logic              play_req;
    logic              is_full;
    logic              wr_en;
    logic              tick_done;
    logic [ADDR_W:0]   rd_next;
    entry_t            head_entry;
    entry_t            next_entry;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        // reset_q masks the first cycle after reset so a key held low through
        // reset release does not look like a fresh press.
        load_req   = !bus.load_n && load_q && !reset_q;
        play_req   = !bus.playback && play_q && !reset_q;
        is_full    = (count == (ADDR_W+1)'(DEPTH));
        // Playback wins over record, and clear wins over both.
        wr_en      = !reset && !bus.clear && (state == S_IDLE) &&
                     load_req && !play_req && !is_full;
        tick_done  = (hold == TICK_W'(NOTE_TICKS - 1));
        // One bit wider than rd_ptr so the end-of-buffer test works at count == DEPTH.
        rd_next    = {1'b0, rd_ptr} + (ADDR_W+1)'(1);
        head_entry = mem[0];
        next_entry = mem[rd_next[ADDR_W-1:0]];
    end

    // NOTE: the note buffer has no reset; its contents are only meaningful below count.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{octave: bus.octave, note: bus.note};
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            load_q    <= 1'b1;
            play_q    <= 1'b1;
            reset_q   <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            hold      <= '0;
            out_entry <= '0;
            note_on   <= 1'b0;
            playing   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            load_q   <= bus.load_n;
            play_q   <= bus.playback;
            reset_q  <= 1'b0;
            overflow <= 1'b0;

            if (bus.clear) begin
                state     <= S_IDLE;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                hold      <= '0;
                out_entry <= '0;
                note_on   <= 1'b0;
                playing   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (play_req) begin
                            // An empty buffer ignores playback and leaves outputs alone.
                            if (count != '0) begin
                                state     <= S_PLAY;
                                rd_ptr    <= '0;
                                hold      <= '0;
                                out_entry <= head_entry;
                                note_on   <= (head_entry.note != 4'd0);
                                playing   <= 1'b1;
                            end
                        end else if (load_req) begin
                            if (is_full) begin
                                overflow <= 1'b1;
                            end else begin
                                wr_ptr <= wr_ptr + ADDR_W'(1);
                                count  <= count + (ADDR_W+1)'(1);
                            end
                        end
                    end

                    S_PLAY: begin
                        if (play_req) begin
                            state     <= S_IDLE;
                            hold      <= '0;
                            out_entry <= '0;
                            note_on   <= 1'b0;
                            playing   <= 1'b0;
                        end else if (tick_done) begin
                            hold   <= '0;
                            rd_ptr <= rd_next[ADDR_W-1:0];
                            if (rd_next < count) begin
                                out_entry <= next_entry;
                                note_on   <= (next_entry.note != 4'd0);
                            end else begin
                                state     <= S_IDLE;
                                out_entry <= '0;
                                note_on   <= 1'b0;
                                playing   <= 1'b0;
                            end
                        end else begin
                            hold <= hold + TICK_W'(1);
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.out_note   = out_entry.note;
    assign bus.out_octave = out_entry.octave;
    assign bus.note_on    = note_on;
    assign bus.playing    = playing;
    assign bus.count      = count;
    assign bus.full       = is_full;
    assign bus.empty      = (count == '0);
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed test of note_sequencer with DEPTH=4, NOTE_TICKS=3.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_note_sequencer;
    localparam int DEPTH      = 4;
    localparam int ADDR_W     = 2;
    localparam int NOTE_TICKS = 3;
    localparam int TICK_W     = 2;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    note_seq_if #(.ADDR_W(ADDR_W)) bus ();

    note_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOTE_TICKS(NOTE_TICKS), .TICK_W(TICK_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input int n, input int o, input int on, input int pl);
        check({tag, ".out_note"},   int'(bus.out_note),   n);
        check({tag, ".out_octave"}, int'(bus.out_octave), o);
        check({tag, ".note_on"},    int'(bus.note_on),    on);
        check({tag, ".playing"},    int'(bus.playing),    pl);
    endtask

    // One load key press: low for one cycle, then released for one cycle.
    task automatic record(input int n, input int o);
        bus.note   = 4'(n);
        bus.octave = 2'(o);
        bus.load_n = 1'b0;
        step();
        bus.load_n = 1'b1;
        step();
    endtask

    task automatic press_play();
        bus.playback = 1'b0;
        step();
        bus.playback = 1'b1;
    endtask

    // Expected {note, octave, note_on} for the four-note recording below.
    int exp4_note [4] = '{3, 4, 6, 7};
    int exp4_oct  [4] = '{1, 1, 2, 3};

    initial begin
        reset        = 1'b1;
        bus.load_n   = 1'b0;   // held low through reset release
        bus.playback = 1'b1;
        bus.clear    = 1'b0;
        bus.note     = 4'd0;
        bus.octave   = 2'd0;
        step(2);
        reset = 1'b0;
        step(3);
        check("reset.count", int'(bus.count), 0);
        check("reset.empty", int'(bus.empty), 1);
        check("reset.full", int'(bus.full), 0);
        check("reset.overflow", int'(bus.overflow), 0);
        check_out("reset", 0, 0, 0, 0);
        bus.load_n = 1'b1;
        step();

        // Three notes, one of them a rest with octave 3.
        record(1, 2);
        record(5, 0);
        record(0, 3);
        check("rec3.count", int'(bus.count), 3);
        check("rec3.empty", int'(bus.empty), 0);
        check("rec3.full", int'(bus.full), 0);
        check("rec3.overflow", int'(bus.overflow), 0);

        press_play();
        for (int c = 1; c <= 10; c++) begin
            string tag;
            tag = $sformatf("play3.c%0d", c);
            if (c <= 3)      check_out(tag, 1, 2, 1, 1);
            else if (c <= 6) check_out(tag, 5, 0, 1, 1);
            else if (c <= 9) check_out(tag, 0, 3, 0, 1);
            else             check_out(tag, 0, 0, 0, 0);
            step();
        end
        check("play3.count_kept", int'(bus.count), 3);

        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check("clear.count", int'(bus.count), 0);
        check("clear.empty", int'(bus.empty), 1);

        // Fill to DEPTH, then one more request overflows.
        for (int i = 0; i < 4; i++) record(exp4_note[i], exp4_oct[i]);
        check("fill.count", int'(bus.count), 4);
        check("fill.full", int'(bus.full), 1);
        bus.note   = 4'd9;
        bus.octave = 2'd0;
        bus.load_n = 1'b0;
        step();
        bus.load_n = 1'b1;
        check("ovf.pulse", int'(bus.overflow), 1);
        check("ovf.count", int'(bus.count), 4);
        step();
        check("ovf.pulse_end", int'(bus.overflow), 0);

        // Full playback confirms all slots, including slot 3, are untouched.
        press_play();
        for (int c = 1; c <= 13; c++) begin
            string tag;
            tag = $sformatf("play4.c%0d", c);
            if (c <= 12) check_out(tag, exp4_note[(c-1)/3], exp4_oct[(c-1)/3], 1, 1);
            else         check_out(tag, 0, 0, 0, 0);
            step();
        end

        // Abort by a second playback request in cycle 5.
        press_play();
        step(4);
        check_out("abort.c5", 4, 1, 1, 1);
        bus.playback = 1'b0;
        step();
        bus.playback = 1'b1;
        check_out("abort.idle", 0, 0, 0, 0);
        check("abort.count", int'(bus.count), 4);
        step();
        check("abort.stays_idle", int'(bus.playing), 0);

        // A held load key writes exactly once.
        bus.clear = 1'b1;
        step();
        bus.clear  = 1'b0;
        bus.note   = 4'd2;
        bus.octave = 2'd1;
        bus.load_n = 1'b0;
        step(20);
        bus.load_n = 1'b1;
        step();
        check("hold.count", int'(bus.count), 1);
        record(12, 2);
        check("hold2.count", int'(bus.count), 2);

        // Simultaneous record and playback: playback wins, no write, no overflow.
        bus.note     = 4'd11;
        bus.load_n   = 1'b0;
        bus.playback = 1'b0;
        step();
        bus.load_n   = 1'b1;
        bus.playback = 1'b1;
        check_out("both", 2, 1, 1, 1);
        check("both.count", int'(bus.count), 2);
        check("both.overflow", int'(bus.overflow), 0);

        // Clear during playback, then playback on an empty buffer is ignored.
        step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check_out("clrplay", 0, 0, 0, 0);
        check("clrplay.count", int'(bus.count), 0);
        check("clrplay.empty", int'(bus.empty), 1);
        press_play();
        check("emptyplay.playing", int'(bus.playing), 0);
        step();
        check("emptyplay.playing2", int'(bus.playing), 0);

        // Reset in the middle of playback discards the recording.
        record(7, 3);
        press_play();
        check("rstplay.playing", int'(bus.playing), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_out("rstplay", 0, 0, 0, 0);
        check("rstplay.count", int'(bus.count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Record/playback controller for the keyboard note path. Captures {octave, note} each time the load key is pressed and stores it in an on-chip note buffer.
- On a playback key press, it replays the stored notes in order, holding each for a fixed number of clock cycles.
- Its outputs drive the tone generator. Inputs come directly from the keyboard conversion logic as active-low levels.

Parameters:
- DEPTH, 32, number of note slots in the buffer (power of two).
- ADDR_W, 5, log2(DEPTH).
- NOTE_TICKS, 12500000, clock cycles each note is held during playback (0.25 s at 50 MHz); must be >= 1.
- TICK_W, 24, width of the hold counter; must satisfy 2^TICK_W > NOTE_TICKS.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_n  in  1  active-low record request level from the keyboard converter.
- playback  in  1  active-low playback request level.
- clear  in  1  active-high; empties the buffer.
- note  in  4  note code: 0 = rest, 1..12 = A..G#.
- octave  in  2  octave 0..3.
- out_note  out  4  note currently sounding.
- out_octave  out  2  octave currently sounding.
- note_on  out  1  high while a non-rest note is being played.
- playing  out  1  high while in PLAY state.
- count  out  ADDR_W+1  number of stored notes, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  one-cycle pulse when a record request is dropped because the buffer is full.

Behaviour:
- Edge detect: registers load_q and play_q sample load_n and playback each cycle; both reset to 1.
  - A request is the cycle where input == 0 and its _q == 1.
  - Holding a key low produces exactly one request.
  - A key held low through reset release produces no request.
- Reset: state IDLE, count 0, wr_ptr 0, rd_ptr 0, hold counter 0, out_note 0, out_octave 0, note_on 0, playing 0, overflow 0. Buffer memory contents are not reset.
- States: IDLE, PLAY.
- IDLE, record request, not full: mem[wr_ptr] <= {octave, note}, sampled in the request cycle; wr_ptr and count increment at that edge. Written data is visible to playback from the next cycle.
- IDLE, record request, full: write dropped, count unchanged, overflow = 1 for exactly the following cycle.
- IDLE, playback request, count > 0: next edge goes to PLAY with rd_ptr = 0, out_note/out_octave = mem[0], note_on = (mem[0].note != 0), playing = 1, hold counter = 0.
- IDLE, playback request, count == 0: ignored; outputs unchanged.
- Simultaneous record and playback requests in IDLE: playback wins; the record request is discarded with no overflow pulse.
- PLAY:
  - The hold counter increments each cycle. When it reaches NOTE_TICKS-1, it resets to 0 and rd_ptr advances.
  - If the new rd_ptr < count: outputs load mem[rd_ptr].
  - Otherwise: go to IDLE with out_note 0, out_octave 0, note_on 0, playing 0.
  - Each note is therefore held exactly NOTE_TICKS cycles. The playing high time is count*NOTE_TICKS cycles.
- PLAY, playback request: abort. Next edge goes to IDLE with outputs zeroed as above.
- PLAY, record request: ignored, no overflow pulse.
- clear (level, any state): at the next edge, count 0, wr_ptr 0, and state IDLE with outputs zeroed. clear takes priority over any request in the same cycle.
- Width rules:
  - wr_ptr and rd_ptr are ADDR_W bits.
  - count is ADDR_W+1 bits so that DEPTH is representable; count never exceeds DEPTH.
  - Recording never wraps; the buffer is linear from slot 0.
- Rest entries (note 0) are stored and played as silence: note_on 0, out_note 0, and out_octave equal to the stored octave.
- reset mid-PLAY: returns to the reset state on the next edge; all stored notes are discarded (count 0).

Test Plan (DEPTH=4, ADDR_W=2, NOTE_TICKS=3, TICK_W=2):
- Record three notes {1,2}, {5,0}, {0,3} via three load_n low pulses -> count=3, empty=0, full=0, no overflow.
- Then pulse playback low for 1 cycle -> starting the edge after the request:
  - cycles 1-3: out_note=1, out_octave=2, note_on=1;
  - cycles 4-6: out_note=5, out_octave=0, note_on=1;
  - cycles 7-9: out_note=0, out_octave=3, note_on=0;
  - cycle 10: playing=0, all outputs 0.
- Record five notes -> count=4 and full=1 after the fourth; the fifth request gives overflow=1 for exactly one cycle and mem[3] is unchanged.
- Hold load_n low for 20 cycles -> exactly one write, count increments by 1.
- Start playback of 4 notes, then a second playback request at cycle 5 -> IDLE on the next edge, outputs 0, count still 4.
- Assert record and playback requests in the same IDLE cycle with count=2 -> PLAY entered, count stays 2.
- Assert clear during PLAY -> next edge: IDLE, count=0, empty=1; a subsequent playback request is ignored with playing staying 0.
